mul_share_arbiter: RTL and testbench
====================================

# mul_share_arbiter

Shares one sequential 4-bit × 4-bit shift-add multiplier among `NREQ` requesters under round-robin arbitration. Each requester presents its operands and raises `req`. The block grants one requester at a time, captures its operands, and runs the shift-add loop at one bit per clock. It then returns the 8-bit unsigned product with the winner's ID. It sits between the small arithmetic clients and the multiply datapath, so each client does not need its own multiplier.

## Interface
- `NREQ`, 4, number of requesters; legal range 2..8.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  NREQ  per-requester request level; sampled only in IDLE.
- `x_in`  input  4*NREQ  multiplicands; requester i uses bits [4i+3:4i].
- `y_in`  input  4*NREQ  multipliers; requester i uses bits [4i+3:4i].
- `ack`  output  NREQ  one-hot, one-cycle pulse: operands of that requester captured.
- `busy`  output  1  high from grant until the cycle in which `done` is asserted.
- `done`  output  1  one-cycle pulse: `p` and `done_id` are valid.
- `done_id`  output  3  index of the requester whose product is on `p`.
- `p`  output  8  unsigned product; held until the next `done`.

## Operation
- States are IDLE, RUN and DONE, all in registers; there are no combinational outputs.
- IDLE:
  - If `req` == 0, remain in IDLE.
  - Otherwise, pick winner w: the first set bit scanning upward from `ptr` and wrapping modulo NREQ.
  - Load B = x_in[w], Q = y_in[w] and A = 0 (A is 5 bits).
  - Set cnt = 0, `ack[w]` = 1, `busy` = 1 and `ptr` = (w+1) mod NREQ, then go to RUN.
- RUN, one iteration per cycle:
  - If Q[0] = 1, A = A + B as a 5-bit sum; the carry lands in A[4].
  - Then shift {A,Q} right by 1 as a 9-bit value, with 0 into the MSB.
  - cnt increments on each iteration. After the 4th iteration (cnt = 3), go to DONE.
- DONE:
  - `p` = {A[3:0],Q}, `done_id` = w, `done` = 1, `busy` = 0, then go to IDLE.
  - A[4] is always 0 at this point; the product of two 4-bit values never exceeds 225.
- `ack` and `done` are high for exactly one cycle each. `ack` is 0 in every state except the cycle after a grant.
- `req` is ignored in RUN and DONE. A request dropped before it is granted is simply not served; nothing is queued.
- A requester that still holds `req` when the block returns to IDLE is treated as a new request.
- `ptr` advances only on a grant. A single persistent requester is therefore granted back-to-back.
- Operand changes after `ack` have no effect on the operation in flight.
- Reset values: state IDLE, `ptr` 0, `ack` 0, `busy` 0, `done` 0, `done_id` 0, `p` 0; A, B, Q and cnt are 0.

## Timing
- Edge k, in IDLE with `req` ≠ 0: grant. `ack[w]` and `busy` are high during cycle k..k+1.
- Edges k+1 through k+4: the four RUN iterations.
- Edge k+5: `done` = 1, `busy` = 0, `p`/`done_id` valid; the state is IDLE.
- Edge k+6: earliest next grant.
- Latency is 5 cycles from the grant edge to `done`. Sustained throughput is one product every 6 cycles.
- When several requests are simultaneous, the one at or after `ptr` wins; the others wait without `ack`.
- Reset asserted mid-RUN:
  - All outputs take their reset values immediately (asynchronously).
  - The in-flight operation is discarded; no `done` follows.
  - After release, arbitration restarts from `ptr` = 0.
- Reset release: the first grant is possible at the first rising edge that sees `rst_n` = 1 and `req` ≠ 0.

## Test plan
- Single request: req = 0001, x0 = 7, y0 = 5 -> `ack` = 0001 one cycle after the grant edge, then `done` 5 cycles after the grant with `p` = 35, `done_id` = 0.
- Maximum operands: req = 0100, x2 = 15, y2 = 15 -> `p` = 225, `done_id` = 2. Zero operand case: x = 9, y = 0 -> `p` = 0.
- All four requesting and held after reset: x_i = i+1, y_i = 3 -> grants in order 0,1,2,3. `done_id` sequence 0,1,2,3 with `p` = 3,6,9,12, with `done` pulses 6 cycles apart.
- Fairness after a grant to requester 2: next IDLE sees req = 1001 -> requester 3 is granted first, then 0.
- A `req` pulse raised and dropped entirely during RUN -> no `ack` and no extra `done`. Changing x/y of the active requester after `ack` -> `p` is unchanged.
- `rst_n` pulsed low at the 2nd RUN cycle -> `busy`, `ack`, `done`, `p` and `done_id` all go to 0 immediately, no `done` follows. After release, req = 0010 is served normally with the correct product.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// Handshake bundle between NREQ requesters and the shared multiplier.
//   req     : per-requester request level
//   x_in    : packed multiplicands, requester i at [4i+3:4i]
//   y_in    : packed multipliers, requester i at [4i+3:4i]
//   ack     : one-hot, one-cycle operand-capture pulse
//   busy    : multiply in flight
//   done    : one-cycle pulse, p/done_id valid
//   done_id : requester index of the product on p
//   p       : 8-bit unsigned product, held until the next done
// The arbiter drives the slave side; requesters drive the master side.
// NREQ must match the NREQ of the attached mul_share_arbiter.
interface mul_share_arbiter_if #(
  parameter int unsigned NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] x_in;
  logic [4*NREQ-1:0] y_in;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              done;
  logic [2:0]        done_id;
  logic [7:0]        p;

  modport master (
    output req, x_in, y_in,
    input  ack, busy, done, done_id, p
  );

  modport slave (
    input  req, x_in, y_in,
    output ack, busy, done, done_id, p
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 shift-add multiplier among NREQ requesters.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_share_arbiter_if slave (req/x_in/y_in in, ack/busy/done/done_id/p out)
// A grant in IDLE captures the winner's operands, four RUN cycles do one
// multiplier bit each, and DONE publishes the product. Every output is a register.
module mul_share_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       id_q, id_d;
  logic [4:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       q_q, q_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       p_q, p_d;

  // Widened copies so the 3-bit winner index can select without width games.
  logic [7:0]       req_ext;
  logic [31:0]      x_ext, y_ext;
  logic [2:0]       win;
  logic             found;
  logic [3:0]       idx;
  logic [4:0]       sum;

  always_comb begin
    req_ext = '0;
    x_ext   = '0;
    y_ext   = '0;
    req_ext[NREQ-1:0]   = bus.req;
    x_ext[4*NREQ-1:0]   = bus.x_in;
    y_ext[4*NREQ-1:0]   = bus.y_in;
  end

  // First set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = {1'b0, ptr_q} + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && req_ext[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
    sum     = q_q[0] ? a_q + {1'b0, b_q} : a_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          b_d     = x_ext[{win, 2'b00} +: 4];
          q_d     = y_ext[{win, 2'b00} +: 4];
          a_d     = '0;
          cnt_d   = '0;
          id_d    = win;
          ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
          busy_d  = 1'b1;
          ptr_d   = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Conditional add, then shift {A,Q} right with 0 into the MSB.
        a_d   = {1'b0, sum[4:1]};
        q_d   = {sum[0], q_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        p_d     = {a_q[3:0], q_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  // done_id only changes at grant time, so it is stable from grant through done.
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = id_q;
  assign bus.p       = p_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.NREQ(4)) bus ();

  mul_share_arbiter #(.NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] x;
    logic [15:0] y;
    int          w;
    int          p;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output int a);
    a = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.ack != 0) begin
        a = int'(bus.ack);
        break;
      end
    end
  endtask

  task automatic wait_done(output int seen, output int id, output int pv);
    seen = 0; id = -1; pv = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1; id = int'(bus.done_id); pv = int'(bus.p);
        break;
      end
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Grant, then expect done exactly 5 edges after the grant edge.
  task automatic run_vec(input vec_t v, input string nm);
    int a, lat, extra;
    bus.req = v.req; bus.x_in = v.x; bus.y_in = v.y;
    wait_ack(a);
    bus.req = '0;
    check({nm, "_ack"}, a, 1 << v.w);
    check({nm, "_busy"}, int'(bus.busy), 1);
    lat = 0; extra = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.ack != 0) extra++;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    check({nm, "_latency"}, lat, 5);
    check({nm, "_extra_ack"}, extra, 0);
    check({nm, "_p"}, int'(bus.p), v.p);
    check({nm, "_id"}, int'(bus.done_id), v.w);
    check({nm, "_busy_at_done"}, int'(bus.busy), 0);
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, int'(bus.done), 0);
    check({nm, "_p_held"}, int'(bus.p), v.p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t vr;
    int a, seen, id, pv, nd, na, cnt_d, cnt_a;
    int acks[4], ids[4], ps[4], acyc[4], dcyc[4];

    vecs[0] = '{req: 4'b0001, x: 16'h0007, y: 16'h0005, w: 0, p: 35};
    vecs[1] = '{req: 4'b0100, x: 16'h0F00, y: 16'h0F00, w: 2, p: 225};
    vecs[2] = '{req: 4'b1000, x: 16'h9000, y: 16'h0000, w: 3, p: 0};
    vecs[3] = '{req: 4'b0010, x: 16'h0060, y: 16'h00B0, w: 1, p: 66};
    vecs[4] = '{req: 4'b1111, x: 16'h4321, y: 16'h3333, w: 2, p: 9};
    vecs[5] = '{req: 4'b0011, x: 16'h005D, y: 16'h002C, w: 0, p: 156};

    bus.req = '0; bus.x_in = '0; bus.y_in = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_ack", int'(bus.ack), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_id", int'(bus.done_id), 0);
    check("rst_p", int'(bus.p), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // All four held after reset: grants 0..3, done every 6 cycles.
    do_reset();
    bus.x_in = 16'h4321; bus.y_in = 16'h3333; bus.req = 4'hF;
    nd = 0; na = 0;
    for (int i = 0; i < 4; i++) begin
      acks[i] = 0; ids[i] = -1; ps[i] = -1; acyc[i] = 0; dcyc[i] = 0;
    end
    for (int c = 1; c <= 40 && nd < 4; c++) begin
      @(posedge clk); #1;
      if (bus.ack != 0 && na < 4) begin
        acks[na] = int'(bus.ack); acyc[na] = c; na++;
      end
      if (bus.done) begin
        ids[nd] = int'(bus.done_id); ps[nd] = int'(bus.p); dcyc[nd] = c; nd++;
      end
    end
    bus.req = '0;
    check("rr_done_count", nd, 4);
    check("rr_first_ack_cycle", acyc[0], 1);
    check("rr_first_done_cycle", dcyc[0], 6);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_ack%0d", i), acks[i], 1 << i);
      check($sformatf("rr_id%0d", i), ids[i], i);
      check($sformatf("rr_p%0d", i), ps[i], 3 * (i + 1));
      if (i > 0) check($sformatf("rr_spacing%0d", i), dcyc[i] - dcyc[i-1], 6);
    end

    // Fairness: after requester 2, req=1001 grants 3 then 0.
    bus.req = 4'b0100;
    wait_ack(a);
    check("fair_first", a, 4);
    bus.req = 4'b1001;
    wait_ack(a);
    check("fair_second", a, 8);
    wait_ack(a);
    check("fair_third", a, 1);
    bus.req = '0;
    wait_done(seen, id, pv);
    check("fair_drain_id", id, 0);
    check("fair_drain_p", pv, 3);

    // Request pulse during RUN is lost; operand change after ack is ignored.
    bus.x_in = 16'h0050; bus.y_in = 16'h0070; bus.req = 4'b0010;
    wait_ack(a);
    bus.req = '0;
    check("run_ack", a, 2);
    bus.x_in = 16'h00F0; bus.y_in = 16'h00F0;
    @(posedge clk); #1;
    bus.req = 4'b0100;
    @(posedge clk); #1;
    bus.req = '0;
    cnt_d = 0; cnt_a = 0; id = -1; pv = -1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (bus.ack != 0) cnt_a++;
      if (bus.done) begin
        cnt_d++; id = int'(bus.done_id); pv = int'(bus.p);
      end
    end
    check("run_pulse_acks", cnt_a, 0);
    check("run_pulse_dones", cnt_d, 1);
    check("run_opchg_p", pv, 35);
    check("run_opchg_id", id, 1);

    // Reset in the 2nd RUN cycle discards the operation.
    bus.x_in = 16'h0003; bus.y_in = 16'h0004; bus.req = 4'b0001;
    wait_ack(a);
    bus.req = '0;
    check("mrst_ack", a, 1);
    @(posedge clk); #3;
    check("mrst_busy_before", int'(bus.busy), 1);
    check("mrst_p_before", int'(bus.p), 35);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_ack_low", int'(bus.ack), 0);
    check("mrst_done", int'(bus.done), 0);
    check("mrst_p", int'(bus.p), 0);
    check("mrst_id", int'(bus.done_id), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_d = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.done) cnt_d++;
    end
    check("mrst_no_done", cnt_d, 0);
    vr = '{req: 4'b0010, x: 16'h0060, y: 16'h0070, w: 1, p: 42};
    run_vec(vr, "mrst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
